// File: rtl/pe_group_sched.sv
// Row sequencer for a 5-tap PE group: loads weights, streams ifmap reads,
// holds the PE enabled through its drain, and turns write-backs into ofmap writes.
module pe_group_sched #(
   parameter int ADDR_W   = 10,
   parameter int CNT_W    = 8,
   parameter int PIPE_LAT = 3,
   parameter int RD_LAT   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  cfg_len,
   input  logic [ADDR_W-1:0] cfg_if_base,
   input  logic [ADDR_W-1:0] cfg_of_base,
   output logic              weight_ld,
   output logic              if_rd_en,
   output logic [ADDR_W-1:0] if_rd_addr,
   output logic              pe_en,
   input  logic              pe_wb_en,
   output logic              of_wr_en,
   output logic [ADDR_W-1:0] of_wr_addr,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [2:0]        dbg_state
);

   // Handshake: start is a one-cycle request honoured only in IDLE; pe_wb_en is a
   // strobe with no back-pressure, each accepted one becomes exactly one of_wr_en.
   typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_RUN, S_DRAIN, S_DONE} state_t;

   localparam int WD   = PIPE_LAT + RD_LAT + 2;
   localparam int WD_W = $clog2(WD + 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  len_q, len_d;
   logic [CNT_W-1:0]  iss_cnt_q, iss_cnt_d;
   logic [CNT_W-1:0]  wb_cnt_q, wb_cnt_d;
   logic [ADDR_W-1:0] if_base_q, if_base_d;
   logic [ADDR_W-1:0] of_base_q, of_base_d;
   logic [WD_W-1:0]   idle_cnt_q, idle_cnt_d;
   logic [RD_LAT-1:0] rd_pipe_q;
   logic              err_q, err_d;
   logic              start_acc, wd_trip, spurious;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         iss_cnt_q  <= '0;
         wb_cnt_q   <= '0;
         if_base_q  <= '0;
         of_base_q  <= '0;
         idle_cnt_q <= '0;
         rd_pipe_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         iss_cnt_q  <= iss_cnt_d;
         wb_cnt_q   <= wb_cnt_d;
         if_base_q  <= if_base_d;
         of_base_q  <= of_base_d;
         idle_cnt_q <= idle_cnt_d;
         err_q      <= err_d;
         rd_pipe_q[0] <= if_rd_en;
         for (int i = 1; i < RD_LAT; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
      end
   end

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      iss_cnt_d  = iss_cnt_q;
      if_base_d  = if_base_q;
      of_base_d  = of_base_q;
      idle_cnt_d = idle_cnt_q;
      weight_ld  = 1'b0;
      if_rd_en   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      start_acc  = 1'b0;
      wd_trip    = 1'b0;

      of_wr_en = pe_wb_en && (state_q == S_RUN || state_q == S_DRAIN) && (wb_cnt_q < len_q);
      spurious = pe_wb_en && !of_wr_en;
      wb_cnt_d = wb_cnt_q + CNT_W'(of_wr_en);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               start_acc  = 1'b1;
               len_d      = cfg_len;
               if_base_d  = cfg_if_base;
               of_base_d  = cfg_of_base;
               iss_cnt_d  = '0;
               wb_cnt_d   = '0;
               idle_cnt_d = '0;
               state_d    = (cfg_len == '0) ? S_DONE : S_LOAD_W;
            end
         end
         S_LOAD_W: begin
            weight_ld = 1'b1;
            busy      = 1'b1;
            state_d   = S_RUN;
         end
         S_RUN: begin
            busy      = 1'b1;
            if_rd_en  = 1'b1;
            iss_cnt_d = iss_cnt_q + CNT_W'(1);
            if (iss_cnt_q == len_q - CNT_W'(1)) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            busy = 1'b1;
            // Completion counts the write happening this cycle so done lands right after it.
            if (wb_cnt_d == len_q) begin
               state_d = S_DONE;
            end else if (pe_wb_en) begin
               idle_cnt_d = '0;
            end else if (idle_cnt_q == WD_W'(WD - 1)) begin
               wd_trip = 1'b1;
               state_d = S_DONE;
            end else begin
               idle_cnt_d = idle_cnt_q + WD_W'(1);
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      err_d = start_acc ? 1'b0 : err_q;
      if (spurious || wd_trip) err_d = 1'b1;
   end

   assign if_rd_addr = if_rd_en ? (if_base_q + ADDR_W'(iss_cnt_q)) : '0;
   assign of_wr_addr = of_wr_en ? (of_base_q + ADDR_W'(wb_cnt_q)) : '0;
   assign pe_en      = rd_pipe_q[RD_LAT-1] || (state_q == S_DRAIN);
   assign err        = err_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_pe_group_sched.sv
// Bench for pe_group_sched: a behavioural PE stub drives write-backs and a
// timing-table reference model fills the expected read/write queues per row.
module tb_pe_group_sched;
   localparam int ADDR_W = 10;
   localparam int CNT_W  = 8;
   localparam int NONE   = 100000;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic [CNT_W-1:0]  cfg_len = '0;
   logic [ADDR_W-1:0] cfg_if_base = '0;
   logic [ADDR_W-1:0] cfg_of_base = '0;
   logic              pe_wb_en = 1'b0;
   logic              weight_ld, if_rd_en, pe_en, of_wr_en, busy, done, err;
   logic [ADDR_W-1:0] if_rd_addr, of_wr_addr;
   logic [2:0]        dbg_state;

   pe_group_sched dut (
      .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
      .cfg_if_base(cfg_if_base), .cfg_of_base(cfg_of_base),
      .weight_ld(weight_ld), .if_rd_en(if_rd_en), .if_rd_addr(if_rd_addr),
      .pe_en(pe_en), .pe_wb_en(pe_wb_en), .of_wr_en(of_wr_en),
      .of_wr_addr(of_wr_addr), .busy(busy), .done(done), .err(err),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_rd_q[$];
   logic [31:0] exp_wr_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] pack_ev(input int cyc, input int addr);
      return {16'(cyc), 16'(addr & ((1 << ADDR_W) - 1))};
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_wld"}, 32'(weight_ld), 0);
      check({tag, "_rd"}, 32'(if_rd_en), 0);
      check({tag, "_rda"}, 32'(if_rd_addr), 0);
      check({tag, "_pe"}, 32'(pe_en), 0);
      check({tag, "_wr"}, 32'(of_wr_en), 0);
      check({tag, "_wra"}, 32'(of_wr_addr), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_err"}, 32'(err), 0);
   endtask

   // Cycle 0 is the start cycle; reads at 2..len+1, writes from 6, done at len+6.
   task automatic run_row(input int len, input int ifb, input int ofb, input int stall, input int inj_c);
      int nres, exp_done, exp_err, done_c, en_cnt;
      int pe_hist[$];
      logic [31:0] ev, ex;
      nres     = (len < stall) ? len : stall;
      exp_done = (len == 0) ? 1 : ((nres == len) ? len + 6 : -1);
      exp_err  = (len != 0 && nres < len) ? 1 : 0;
      exp_rd_q.delete();
      exp_wr_q.delete();
      for (int i = 0; i < len; i++) exp_rd_q.push_back(pack_ev(i + 2, ifb + i));
      for (int i = 0; i < nres; i++) exp_wr_q.push_back(pack_ev(i + 6, ofb + i));
      done_c = -1;
      en_cnt = 0;

      @(negedge clk);
      start = 1'b1;
      cfg_len = CNT_W'(len);
      cfg_if_base = ADDR_W'(ifb);
      cfg_of_base = ADDR_W'(ofb);
      pe_wb_en = 1'b0;
      #1;
      pe_hist.push_back(0);

      for (int c = 1; c <= len + 40; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == inj_c) begin
            start = 1'b1;
            cfg_len = 8'd9;
            cfg_if_base = ADDR_W'($urandom);
            cfg_of_base = ADDR_W'($urandom);
         end
         pe_wb_en = (c >= 3) && (pe_hist[c-3] != 0) && (pe_hist[c-3] <= nres);
         #1;
         if (pe_en) en_cnt++;
         pe_hist.push_back(pe_en ? en_cnt : 0);

         check("weight_ld", 32'(weight_ld), 32'(len != 0 && c == 1));
         if (if_rd_en) begin
            ev = pack_ev(c, int'(if_rd_addr));
            ex = (exp_rd_q.size() != 0) ? exp_rd_q.pop_front() : 32'hDEAD_BEEF;
            check("rd_cyc_addr", ev, ex);
         end
         if (of_wr_en) begin
            ev = pack_ev(c, int'(of_wr_addr));
            ex = (exp_wr_q.size() != 0) ? exp_wr_q.pop_front() : 32'hDEAD_BEEF;
            check("wr_cyc_addr", ev, ex);
         end
         if (c == 1) check("err_cleared", 32'(err), 0);
         if (exp_done >= 0) begin
            check("done", 32'(done), 32'(c == exp_done));
            check("busy", 32'(busy), 32'(c < exp_done));
            check("pe_en", 32'(pe_en), 32'(len != 0 && c >= 3 && c <= len + 5));
         end else if (c <= len + 1) begin
            check("busy_run", 32'(busy), 1);
         end
         if (done && done_c < 0) begin
            done_c = c;
            check("err_at_done", 32'(err), 32'(exp_err));
         end
         if (done_c >= 0 && c == done_c + 1) begin
            check("idle_busy", 32'(busy), 0);
            check("idle_wld", 32'(weight_ld), 0);
            break;
         end
      end
      pe_wb_en = 1'b0;
      start = 1'b0;
      check("done_seen", 32'(done_c >= 0), 1);
      check("rd_left", 32'(exp_rd_q.size()), 0);
      check("wr_left", 32'(exp_wr_q.size()), 0);
   endtask

   task automatic abort_row();
      @(negedge clk);
      start = 1'b1;
      cfg_len = 8'd4;
      cfg_if_base = 10'h020;
      cfg_of_base = 10'h200;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("abort_busy_before", 32'(busy), 1);
      rst = 1'b0;
      #1;
      check_all_zero("abort");
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("abort_no_done", 32'(done), 0);
         check("abort_no_busy", 32'(busy), 0);
      end
      rst = 1'b1;
   endtask

   task automatic spurious_wb();
      @(negedge clk);
      pe_wb_en = 1'b1;
      #1;
      check("spur_no_wr", 32'(of_wr_en), 0);
      @(negedge clk);
      pe_wb_en = 1'b0;
      #1;
      check("spur_err", 32'(err), 1);
   endtask

   initial begin
      int len, stall;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b1;

      run_row(4, 'h010, 'h100, NONE, -1);
      run_row(0, 'h010, 'h100, NONE, -1);
      run_row(3, 'h3FE, 'h3FF, NONE, -1);
      run_row(4, 'h010, 'h100, NONE, 3);
      run_row(5, 'h055, 'h0AA, NONE, 11);
      abort_row();
      run_row(4, 'h030, 'h300, NONE, -1);
      run_row(4, 'h010, 'h100, 2, -1);
      spurious_wb();
      run_row(2, 'h111, 'h222, NONE, -1);
      run_row(255, 'h3F0, 'h3F8, NONE, -1);

      for (int r = 0; r < 25; r++) begin
         len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 24));
         stall = (len > 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, len - 1)) : NONE;
         run_row(len, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), stall, -1);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got 0x0 expected 0x1");
      $fatal(1, "bench time limit");
   end
endmodule
